meter_pulse_counter: RTL and testbench
======================================

# meter_pulse_counter

Avalon-MM slave that counts energy-metering pulses (CF output of the metering front end) in measurement windows delimited by the system timer's interrupt output. Each rising edge of `tick_in`, wired to the timer `irq`, closes the current window. On close, the block latches the window count, adds it to a 32-bit running total and raises its own interrupt. It sits on the same 16-bit register bus as the timer, directly downstream of it.

## Interface
- `DEB_W`, 8, width of the debounce length register and its filter counter.
- `clk` in 1, system clock.
- `reset_n` in 1, asynchronous active-low reset.
- `address` in 3, register select.
- `chipselect` in 1, slave select.
- `write_n` in 1, active-low write.
- `writedata` in 16, write data.
- `readdata` out 16, registered read data.
- `irq` out 1, window-done interrupt, level.
- `tick_in` in 1, window tick; same clock domain; rising edge is significant.
- `pulse_in` in 1, raw asynchronous meter pulse.

One clock; reset is asynchronous and active-low (`clk`, `reset_n`).

## Operation
- Register map:
  - 0 status: bit0 `window_done`, bit1 `missed` (window closed while `window_done` still set), bit2 `saturated`, bit3 `enabled`. Any write clears bits 0–2.
  - 1 control: bit0 `irq_en`, bit1 `count_en`, bit2 `clear` (strobe, reads 0).
  - 2 `last_window`, 16-bit.
  - 3 `total_l`. Reading it copies `total[31:16]` into `total_shadow`.
  - 4 `total_shadow`.
  - 5 `debounce_len`, `[DEB_W-1:0]`.
  - 6 `live_window`.
  - 7 `peak_window`.
- Pulse path:
  - 2-flop synchronizer, then a debounce filter.
  - The filter holds state `filt`. It counts consecutive cycles where the synchronized input differs from `filt`, and resets the count whenever they agree.
  - When the count reaches `max(debounce_len, 1)`, `filt` toggles.
  - A 0→1 toggle of `filt` produces a one-cycle `pulse_acc`.
- Filter state machine: LOW, QUAL_HIGH, HIGH, QUAL_LOW. The QUAL states return to their origin on a mismatch before the count completes.
- `live_window` increments on `pulse_acc` when `count_en`=1. It saturates at 0xFFFF and sets `saturated`.
- Tick handling: `tick_edge` = `tick_in` & ~`tick_d`. When `tick_edge` occurs and `count_en`=1:
  - `last_window` ← `live_window`.
  - `total` ← `total` + `live_window` (mod 2^32).
  - `peak_window` ← max(`peak_window`, `live_window`).
  - `live_window` ← 0.
  - `window_done` ← 1, and `missed` ← 1 if `window_done` was already 1.
- `count_en`=0: pulses and ticks are ignored, counters frozen, filter keeps running.
- `irq` = `window_done` & `irq_en`.
- `clear` strobe: `live_window`, `last_window`, `total`, `total_shadow`, `peak_window` and status bits 0–2 go to 0. Control and debounce settings are unchanged.

## Timing
- Reset values:
  - `readdata` 0, `irq` 0, status 0, control 0.
  - All counts 0, `debounce_len` 4.
  - Filter in LOW, `tick_d` 0, synchronizer flops 0.
- Reads: `readdata` is registered, so data appears on the edge after `address` is presented (1-cycle latency). The `total_shadow` capture happens on that same edge.
- Writes take effect on the edge where `chipselect` & ~`write_n` are both 1.
- Pulse latency: if `pulse_in` first samples high at edge k and stays stable, `pulse_acc` is high after edge k+2+N and `live_window` increments at edge k+3+N, where N = `max(debounce_len, 1)`.
- A tick edge and `pulse_acc` in the same cycle: the closing window excludes the pulse, and `live_window` becomes 1.
- A tick edge and a status write in the same cycle: the set wins (`window_done`=1).
- A `clear` and a tick edge in the same cycle: `clear` wins; nothing is latched and `window_done`=0.
- Writing `debounce_len` mid-qualification: the new value applies from the next compare; an in-progress count ≥ the new N toggles `filt` on the next cycle.
- Async reset mid-window: all state returns to reset values immediately.

## Structure
- Package `meter_pkg`:
  - register address constants 0–7;
  - status and control bit indices;
  - `DEBOUNCE_RESET`=4;
  - filter state enum.
- Sub-module `pulse_debounce` (synchronizer + filter FSM + edge output `pulse_acc`). All other logic stays in the top level.

## Test plan
- Reset, then read every address → 0, except address 5 → 4; `irq` 0.
- Control=0x0003, `debounce_len`=4, then 10 clean pulses each 8 cycles high / 8 low, then `tick_in` rise → `last_window`=10, `total_l`=10, `total_shadow`=0 after the `total_l` read, `irq`=1; a status write drops `irq` the next cycle.
- Glitch of 3 cycles on `pulse_in` with `debounce_len`=4 → no count. Same with 4 cycles → 1 count, incremented at edge k+7.
- Two tick edges without a status write → `missed`=1. Total 0xFFFF_FFF0 plus a window of 0x20 → total wraps to 0x0000_0010.
- 0x10000 pulses in one window → `live_window` holds 0xFFFF and `saturated`=1. Then an accepted pulse coincident with a tick edge → new `live_window`=1.
- `clear` coincident with a tick edge → all counts 0, `window_done`=0, `irq` 0. Assert `reset_n` mid-qualification → filter returns to LOW and no count results.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared constants for the meter pulse counter: register map, status and
// control bit positions, debounce reset length and the filter state encoding.
package meter_pkg;

   // Register addresses on the 16-bit slave bus
   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_LAST     = 3'd2;
   localparam logic [2:0] ADDR_TOTAL_L  = 3'd3;
   localparam logic [2:0] ADDR_SHADOW   = 3'd4;
   localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;
   localparam logic [2:0] ADDR_LIVE     = 3'd6;
   localparam logic [2:0] ADDR_PEAK     = 3'd7;

   // Status register bits
   localparam int STAT_WINDOW_DONE = 0;
   localparam int STAT_MISSED      = 1;
   localparam int STAT_SATURATED   = 2;
   localparam int STAT_ENABLED     = 3;

   // Control register bits
   localparam int CTRL_IRQ_EN   = 0;
   localparam int CTRL_COUNT_EN = 1;
   localparam int CTRL_CLEAR    = 2;

   // Debounce length loaded at reset
   localparam int DEBOUNCE_RESET = 4;

   // Debounce filter states; the QUAL states are qualifying a change of level
   typedef enum logic [1:0] {
      FILT_LOW       = 2'd0,
      FILT_QUAL_HIGH = 2'd1,
      FILT_HIGH      = 2'd2,
      FILT_QUAL_LOW  = 2'd3
   } filt_state_t;

endpackage

// File: rtl/pulse_debounce.sv
// Meter pulse front end: 2-flop synchronizer, level filter that needs
// max(debounce_len,1) consecutive disagreeing samples to change its level,
// and a one-cycle pulse_acc on every accepted 0->1 change.
module pulse_debounce
   import meter_pkg::*;
#(
   parameter int DEB_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DEB_W-1:0] debounce_len,
   input  logic             pulse_in,
   output logic             pulse_acc
);

   logic             sync_1;
   logic             sync_2;
   filt_state_t      state;
   filt_state_t      state_next;
   logic [DEB_W-1:0] cnt;
   logic [DEB_W-1:0] cnt_next;
   logic [DEB_W:0]   cnt_inc;
   logic [DEB_W:0]   len_eff;
   logic             filt;
   logic             filt_d;
   logic             mismatch;
   logic             hit;

   // Bring the asynchronous meter pulse into the clk domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= pulse_in;
         sync_2 <= sync_1;
      end
   end

   // Filter next state: count disagreeing samples, toggle when the count
   // including this sample reaches the effective length
   always_comb begin
      len_eff    = {1'b0, debounce_len};
      cnt_inc    = {1'b0, cnt} + {{DEB_W{1'b0}}, 1'b1};
      filt       = (state == FILT_HIGH) || (state == FILT_QUAL_LOW);
      mismatch   = (sync_2 != filt);
      hit        = 1'b0;
      cnt_next   = '0;
      state_next = state;
      if (debounce_len == '0) begin
         len_eff = {{DEB_W{1'b0}}, 1'b1};
      end
      hit = mismatch && (cnt_inc >= len_eff);
      if (mismatch && !hit) begin
         cnt_next = cnt_inc[DEB_W-1:0];
      end
      case (state)
         FILT_LOW, FILT_QUAL_HIGH: begin
            if (!mismatch) state_next = FILT_LOW;
            else if (hit)  state_next = FILT_HIGH;
            else           state_next = FILT_QUAL_HIGH;
         end
         FILT_HIGH, FILT_QUAL_LOW: begin
            if (!mismatch) state_next = FILT_HIGH;
            else if (hit)  state_next = FILT_LOW;
            else           state_next = FILT_QUAL_LOW;
         end
         default: state_next = FILT_LOW;
      endcase
   end

   // Filter state, qualification count and the registered rising-edge output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FILT_LOW;
         cnt       <= '0;
         filt_d    <= 1'b0;
         pulse_acc <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         filt_d    <= filt;
         pulse_acc <= filt & ~filt_d;
      end
   end

endmodule

// File: rtl/meter_pulse_counter.sv
// Avalon-MM slave counting debounced meter pulses per measurement window.
// A rising edge of tick_in closes the window: the count is latched, added
// to the 32-bit total, compared against the peak, and window_done is set.
module meter_pulse_counter
   import meter_pkg::*;
#(
   parameter int DEB_W = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   input  logic        tick_in,
   input  logic        pulse_in
);

   logic             wr_en;
   logic             rd_en;
   logic             status_wr;
   logic             control_wr;
   logic             debounce_wr;
   logic             clear;
   logic             tick_d;
   logic             tick_edge;
   logic             tick_acc;
   logic             pulse_acc;
   logic             pulse_cnt;
   logic             sat_hit;
   logic             irq_en;
   logic             count_en;
   logic             window_done;
   logic             missed;
   logic             saturated;
   logic [DEB_W-1:0] debounce_len;
   logic [15:0]      live_window;
   logic [15:0]      last_window;
   logic [15:0]      total_shadow;
   logic [15:0]      peak_window;
   logic [15:0]      rd_mux;
   logic [31:0]      total;
   logic             unused_wd;

   pulse_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk          (clk),
      .reset_n      (reset_n),
      .debounce_len (debounce_len),
      .pulse_in     (pulse_in),
      .pulse_acc    (pulse_acc)
   );

   // Bus decode and event qualification; count_en gates both pulses and ticks
   always_comb begin
      wr_en       = chipselect & ~write_n;
      rd_en       = chipselect & write_n;
      status_wr   = wr_en && (address == ADDR_STATUS);
      control_wr  = wr_en && (address == ADDR_CONTROL);
      debounce_wr = wr_en && (address == ADDR_DEBOUNCE);
      clear       = control_wr && writedata[CTRL_CLEAR];
      tick_edge   = tick_in & ~tick_d;
      tick_acc    = tick_edge & count_en;
      pulse_cnt   = pulse_acc & count_en;
      sat_hit     = pulse_cnt && !tick_acc && (live_window == 16'hFFFF);
      irq         = window_done & irq_en;
      unused_wd   = ^writedata;
   end

   // Tick edge detector
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tick_d <= 1'b0;
      else          tick_d <= tick_in;
   end

   // Control and debounce settings; clear is a strobe and is not stored
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en       <= 1'b0;
         count_en     <= 1'b0;
         debounce_len <= DEB_W'(DEBOUNCE_RESET);
      end else begin
         if (control_wr) begin
            irq_en   <= writedata[CTRL_IRQ_EN];
            count_en <= writedata[CTRL_COUNT_EN];
         end
         if (debounce_wr) begin
            debounce_len <= writedata[DEB_W-1:0];
         end
      end
   end

   // Window counters; a pulse coincident with a tick opens the new window
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         live_window  <= '0;
         last_window  <= '0;
         total        <= '0;
         total_shadow <= '0;
         peak_window  <= '0;
      end else if (clear) begin
         live_window  <= '0;
         last_window  <= '0;
         total        <= '0;
         total_shadow <= '0;
         peak_window  <= '0;
      end else begin
         if (tick_acc) begin
            last_window <= live_window;
            total       <= total + {16'h0000, live_window};
            if (live_window > peak_window) peak_window <= live_window;
            live_window <= pulse_cnt ? 16'h0001 : 16'h0000;
         end else if (pulse_cnt && (live_window != 16'hFFFF)) begin
            live_window <= live_window + 16'h0001;
         end
         if (rd_en && (address == ADDR_TOTAL_L)) begin
            total_shadow <= total[31:16];
         end
      end
   end

   // Sticky status bits; a set event wins over a status write, clear wins over all
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         window_done <= 1'b0;
         missed      <= 1'b0;
         saturated   <= 1'b0;
      end else if (clear) begin
         window_done <= 1'b0;
         missed      <= 1'b0;
         saturated   <= 1'b0;
      end else begin
         if (tick_acc)       window_done <= 1'b1;
         else if (status_wr) window_done <= 1'b0;
         if (tick_acc && window_done) missed <= 1'b1;
         else if (status_wr)          missed <= 1'b0;
         if (sat_hit)        saturated <= 1'b1;
         else if (status_wr) saturated <= 1'b0;
      end
   end

   // Read data selection
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_STATUS: begin
            rd_mux[STAT_WINDOW_DONE] = window_done;
            rd_mux[STAT_MISSED]      = missed;
            rd_mux[STAT_SATURATED]   = saturated;
            rd_mux[STAT_ENABLED]     = count_en;
         end
         ADDR_CONTROL: begin
            rd_mux[CTRL_IRQ_EN]   = irq_en;
            rd_mux[CTRL_COUNT_EN] = count_en;
         end
         ADDR_LAST:     rd_mux = last_window;
         ADDR_TOTAL_L:  rd_mux = total[15:0];
         ADDR_SHADOW:   rd_mux = total_shadow;
         ADDR_DEBOUNCE: rd_mux[DEB_W-1:0] = debounce_len;
         ADDR_LIVE:     rd_mux = live_window;
         ADDR_PEAK:     rd_mux = peak_window;
         default:       rd_mux = '0;
      endcase
   end

   // Registered read data, one cycle after the address is presented
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   readdata <= '0;
      else if (rd_en) readdata <= rd_mux;
   end

endmodule

// File: tb/tb_meter_pulse_counter.sv
// Directed bench for meter_pulse_counter. Inputs change on the falling edge,
// outputs are sampled on the falling edge, the DUT acts on the rising edge.
module tb_meter_pulse_counter;
   import meter_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        irq;
   logic        tick_in;
   logic        pulse_in;

   int          n_checks;
   int          n_pass;
   logic [15:0] rd;

   meter_pulse_counter #(.DEB_W(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .tick_in    (tick_in),
      .pulse_in   (pulse_in)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      cyc(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      cyc(1);
      chipselect = 1'b0;
      d          = readdata;
   endtask

   task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
      logic [15:0] v;
      bus_read(a, v);
      check(tag, {16'h0000, v}, {16'h0000, exp});
   endtask

   task automatic pulses(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         pulse_in = 1'b1;
         cyc(hi);
         pulse_in = 1'b0;
         cyc(lo);
      end
   endtask

   task automatic tick();
      tick_in = 1'b1;
      cyc(2);
      tick_in = 1'b0;
      cyc(2);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = '0;
      writedata  = '0;
      tick_in    = 1'b0;
      pulse_in   = 1'b0;
      cyc(3);
      reset_n = 1'b1;
      cyc(1);

      // Reset state
      check("rst_readdata", {16'h0000, readdata}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_filt", 32'(dut.u_deb.state), 32'(FILT_LOW));
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), rd);
         check($sformatf("rst_reg%0d", a), {16'h0000, rd}, (a == 5) ? 32'h4 : 32'h0);
      end

      // Ten clean pulses then a window close
      bus_write(ADDR_CONTROL, 16'h0003);
      bus_write(ADDR_DEBOUNCE, 16'h0004);
      read_check("ctrl_rb", ADDR_CONTROL, 16'h0003);
      read_check("stat_en", ADDR_STATUS, 16'h0008);
      pulses(10, 8, 8);
      read_check("live_10", ADDR_LIVE, 16'h000A);
      tick();
      check("irq_set", {31'h0, irq}, 32'h1);
      read_check("last_10", ADDR_LAST, 16'h000A);
      read_check("total_10", ADDR_TOTAL_L, 16'h000A);
      read_check("shadow_0", ADDR_SHADOW, 16'h0000);
      read_check("peak_10", ADDR_PEAK, 16'h000A);
      read_check("live_0", ADDR_LIVE, 16'h0000);
      read_check("stat_done", ADDR_STATUS, 16'h0009);
      bus_write(ADDR_STATUS, 16'h0000);
      check("irq_drop", {31'h0, irq}, 32'h0);

      // Glitches: 3 cycles rejected, 4 cycles accepted at edge k+7
      pulses(1, 3, 10);
      check("glitch3", {16'h0000, dut.live_window}, 32'h0);
      pulse_in = 1'b1;
      cyc(4);
      pulse_in = 1'b0;
      cyc(3);
      check("glitch4_k6", {16'h0000, dut.live_window}, 32'h0);
      cyc(1);
      check("glitch4_k7", {16'h0000, dut.live_window}, 32'h1);
      cyc(4);

      // Two ticks without acknowledge
      tick();
      tick();
      read_check("stat_missed", ADDR_STATUS, 16'h000B);
      read_check("last_0", ADDR_LAST, 16'h0000);
      read_check("total_11", ADDR_TOTAL_L, 16'h000B);
      read_check("peak_keep", ADDR_PEAK, 16'h000A);
      bus_write(ADDR_STATUS, 16'hFFFF);
      read_check("stat_ack", ADDR_STATUS, 16'h0008);

      // Total wrap: preload 0xFFFF_FFF0, then a window of 0x20
      bus_write(ADDR_DEBOUNCE, 16'h0001);
      force dut.total = 32'hFFFF_FFF0;
      #1;
      release dut.total;
      pulses(32, 3, 3);
      cyc(3);
      read_check("live_20", ADDR_LIVE, 16'h0020);
      read_check("total_pre_l", ADDR_TOTAL_L, 16'hFFF0);
      read_check("total_pre_h", ADDR_SHADOW, 16'hFFFF);
      tick();
      read_check("wrap_l", ADDR_TOTAL_L, 16'h0010);
      read_check("wrap_h", ADDR_SHADOW, 16'h0000);
      read_check("last_20", ADDR_LAST, 16'h0020);
      read_check("peak_20", ADDR_PEAK, 16'h0020);
      bus_write(ADDR_STATUS, 16'h0000);

      // Saturation: preload 0xFFFE, two pulses
      force dut.live_window = 16'hFFFE;
      #1;
      release dut.live_window;
      pulses(1, 3, 3);
      cyc(3);
      check("sat_ffff", {16'h0000, dut.live_window}, 32'hFFFF);
      read_check("stat_nosat", ADDR_STATUS, 16'h0008);
      pulses(1, 3, 3);
      cyc(3);
      check("sat_hold", {16'h0000, dut.live_window}, 32'hFFFF);
      read_check("stat_sat", ADDR_STATUS, 16'h000C);

      // Accepted pulse coincident with a tick edge (N=1: pulse_acc after k+3)
      pulse_in = 1'b1;
      cyc(4);
      check("coinc_acc", {31'h0, dut.u_deb.pulse_acc}, 32'h1);
      tick_in = 1'b1;
      cyc(1);
      check("coinc_live", {16'h0000, dut.live_window}, 32'h1);
      pulse_in = 1'b0;
      tick_in  = 1'b0;
      cyc(5);
      read_check("coinc_last", ADDR_LAST, 16'hFFFF);
      read_check("coinc_stat", ADDR_STATUS, 16'h000D);
      read_check("coinc_tot_l", ADDR_TOTAL_L, 16'h000F);
      read_check("coinc_tot_h", ADDR_SHADOW, 16'h0001);
      read_check("coinc_peak", ADDR_PEAK, 16'hFFFF);
      check("coinc_irq", {31'h0, irq}, 32'h1);

      // Clear coincident with a tick edge
      tick_in = 1'b1;
      bus_write(ADDR_CONTROL, 16'h0007);
      tick_in = 1'b0;
      check("clr_irq", {31'h0, irq}, 32'h0);
      check("clr_live", {16'h0000, dut.live_window}, 32'h0);
      cyc(2);
      read_check("clr_stat", ADDR_STATUS, 16'h0008);
      read_check("clr_last", ADDR_LAST, 16'h0000);
      read_check("clr_tot_l", ADDR_TOTAL_L, 16'h0000);
      read_check("clr_shadow", ADDR_SHADOW, 16'h0000);
      read_check("clr_peak", ADDR_PEAK, 16'h0000);
      read_check("clr_ctrl", ADDR_CONTROL, 16'h0003);
      read_check("clr_deb", ADDR_DEBOUNCE, 16'h0001);

      // Async reset during qualification
      bus_write(ADDR_DEBOUNCE, 16'h0006);
      pulse_in = 1'b1;
      cyc(3);
      check("qual_state", 32'(dut.u_deb.state), 32'(FILT_QUAL_HIGH));
      reset_n = 1'b0;
      #1;
      check("arst_filt", 32'(dut.u_deb.state), 32'(FILT_LOW));
      check("arst_irq", {31'h0, irq}, 32'h0);
      check("arst_rd", {16'h0000, readdata}, 32'h0);
      pulse_in = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(12);
      check("arst_filt2", 32'(dut.u_deb.state), 32'(FILT_LOW));
      check("arst_live", {16'h0000, dut.live_window}, 32'h0);
      read_check("arst_deb", ADDR_DEBOUNCE, 16'h0004);
      read_check("arst_ctrl", ADDR_CONTROL, 16'h0000);

      // count_en=0: pulses and ticks ignored
      pulses(1, 8, 8);
      check("frozen_live", {16'h0000, dut.live_window}, 32'h0);
      tick();
      read_check("frozen_stat", ADDR_STATUS, 16'h0000);
      read_check("frozen_last", ADDR_LAST, 16'h0000);
      check("frozen_irq", {31'h0, irq}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
